// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer: register offsets, CTRL bit
// positions, FSM state encoding and a byte-lane write-merge helper.
package apb_timer_pkg;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_PRESCALE = 8'h04;
    localparam logic [7:0] OFF_COMPARE  = 8'h08;
    localparam logic [7:0] OFF_COUNT    = 8'h0C;
    localparam logic [7:0] OFF_STATUS   = 8'h10;

    localparam int CTRL_EN = 0;
    localparam int CTRL_AR = 1;
    localparam int CTRL_IE = 2;

    typedef enum logic [1:0] {
        APB_TIMER_IDLE = 2'd0,
        APB_TIMER_RUN  = 2'd1,
        APB_TIMER_DONE = 2'd2
    } timer_state_e;

    function automatic logic [31:0] merge_strb(
        input logic [31:0] old_val,
        input logic [31:0] wdata,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_timer_prescaler.sv
// Clock divider: pulses tick_o for one cycle every prescale_i+1 cycles
// while run_i is high; clear_i restarts the division period.
// Ports: clk_i, arst_ni, run_i, clear_i, prescale_i[15:0] -> tick_o.
module apb_timer_prescaler (
    input  logic        clk_i,
    input  logic        arst_ni,
    input  logic        run_i,
    input  logic        clear_i,
    input  logic [15:0] prescale_i,
    output logic        tick_o
);

    logic [15:0] cnt_q;

    // >= keeps the divider from running away if prescale shrinks
    assign tick_o = run_i && (cnt_q >= prescale_i);

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q <= '0;
        end else if (clear_i || !run_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: rtl/apb_timer.sv
// APB timer: 32-bit up-counter with prescaler, compare match, one-shot or
// auto-reload, sticky W1C match flag and level irq_o = match & ie.
// Ports: clk_i, arst_ni, APB completer (psel/penable/paddr/pwrite/pwdata/
// pstrb -> pready/prdata/pslverr), irq_o.
// Build option: APB_TIMER_SLVERR_EN enables pslverr_o on unmapped
// offsets and on writes with all strobes low.
module apb_timer
    import apb_timer_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    arst_ni,
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic [ADDR_WIDTH-1:0]   paddr_i,
    input  logic                    pwrite_i,
    input  logic [DATA_WIDTH-1:0]   pwdata_i,
    input  logic [DATA_WIDTH/8-1:0] pstrb_i,
    output logic                    pready_o,
    output logic [DATA_WIDTH-1:0]   prdata_o,
    output logic                    pslverr_o,
    output logic                    irq_o
);

    if (DATA_WIDTH != 32) begin : g_dw_check
        $fatal(1, "apb_timer: DATA_WIDTH must be 32");
    end

    timer_state_e state_q, state_d;
    logic [2:0]   ctrl_q;
    logic [15:0]  prescale_q;
    logic [31:0]  compare_q;
    logic [31:0]  count_q;
    logic         match_q;

    logic [7:0] offs;
    logic       access, err, wr_en, rd_en;
    logic       wr_ctrl, wr_prescale, wr_compare, wr_count, wr_status;
    logic       en_wr, run, tick, hit, pre_clear;

    // Only offset bits [7:2] take part in decode
    logic unused_addr;
    assign unused_addr = ^{paddr_i[ADDR_WIDTH-1:8], paddr_i[1:0]};

    assign offs   = {paddr_i[7:2], 2'b00};
    assign access = psel_i && penable_i;

`ifdef APB_TIMER_SLVERR_EN
    logic unmapped;
    assign unmapped = paddr_i[7:2] > 6'd4;
    assign err = access && (unmapped || (pwrite_i && (pstrb_i == '0)));
`else
    assign err = 1'b0;
`endif

    assign wr_en = access && pwrite_i && !err;
    assign rd_en = access && !pwrite_i && !err;

    assign wr_ctrl     = wr_en && (offs == OFF_CTRL);
    assign wr_prescale = wr_en && (offs == OFF_PRESCALE);
    assign wr_compare  = wr_en && (offs == OFF_COMPARE);
    assign wr_count    = wr_en && (offs == OFF_COUNT);
    assign wr_status   = wr_en && (offs == OFF_STATUS);

    assign en_wr = wr_ctrl && pstrb_i[0];
    assign run   = (state_q == APB_TIMER_RUN);
    assign hit   = run && tick && (count_q == compare_q);

    assign pre_clear = wr_prescale ||
                       ((state_q != APB_TIMER_RUN) &&
                        (state_d == APB_TIMER_RUN));

    apb_timer_prescaler u_prescaler (
        .clk_i      (clk_i),
        .arst_ni    (arst_ni),
        .run_i      (run),
        .clear_i    (pre_clear),
        .prescale_i (prescale_q),
        .tick_o     (tick)
    );

    // A CTRL.en write always wins over the one-shot stop
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            APB_TIMER_IDLE: begin
                if (en_wr && pwdata_i[CTRL_EN]) state_d = APB_TIMER_RUN;
            end
            APB_TIMER_RUN: begin
                if (en_wr) begin
                    state_d = pwdata_i[CTRL_EN] ? APB_TIMER_RUN
                                                : APB_TIMER_IDLE;
                end else if (hit && !ctrl_q[CTRL_AR]) begin
                    state_d = APB_TIMER_DONE;
                end
            end
            APB_TIMER_DONE: begin
                if (en_wr) begin
                    state_d = pwdata_i[CTRL_EN] ? APB_TIMER_RUN
                                                : APB_TIMER_IDLE;
                end
            end
            default: state_d = APB_TIMER_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= APB_TIMER_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            compare_q  <= '0;
            count_q    <= '0;
            match_q    <= 1'b0;
        end else begin
            if (en_wr) begin
                ctrl_q <= pwdata_i[2:0];
            end else if (hit && !ctrl_q[CTRL_AR]) begin
                ctrl_q[CTRL_EN] <= 1'b0;
            end

            if (wr_prescale) begin
                if (pstrb_i[0]) prescale_q[7:0]  <= pwdata_i[7:0];
                if (pstrb_i[1]) prescale_q[15:8] <= pwdata_i[15:8];
            end

            if (wr_compare) begin
                compare_q <= merge_strb(compare_q, pwdata_i, pstrb_i);
            end

            // Software load of COUNT overrides the tick update
            if (wr_count) begin
                count_q <= merge_strb(count_q, pwdata_i, pstrb_i);
            end else if (hit) begin
                if (ctrl_q[CTRL_AR]) count_q <= '0;
            end else if (run && tick) begin
                count_q <= count_q + 32'd1;
            end

            // Hardware set beats a same-cycle W1C
            if (hit) begin
                match_q <= 1'b1;
            end else if (wr_status && pstrb_i[0] && pwdata_i[0]) begin
                match_q <= 1'b0;
            end
        end
    end

    always_comb begin
        prdata_o = '0;
        if (rd_en) begin
            unique case (1'b1)
                (offs == OFF_CTRL):     prdata_o = {29'd0, ctrl_q};
                (offs == OFF_PRESCALE): prdata_o = {16'd0, prescale_q};
                (offs == OFF_COMPARE):  prdata_o = compare_q;
                (offs == OFF_COUNT):    prdata_o = count_q;
                (offs == OFF_STATUS):   prdata_o = {31'd0, match_q};
                default:                prdata_o = '0;
            endcase
        end
    end

    assign pready_o  = 1'b1;
    assign pslverr_o = err;
    assign irq_o     = match_q && ctrl_q[CTRL_IE];

endmodule

// File: tb/tb_apb_timer.sv
// Bench for apb_timer: directed scenarios plus random APB traffic,
// checked against a cycle-level behavioural model of the register map.
module tb_apb_timer;
    import apb_timer_pkg::*;

`ifdef APB_TIMER_SLVERR_EN
    localparam bit SLVERR = 1'b1;
`else
    localparam bit SLVERR = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        arst_ni = 1'b0;
    logic        psel_i, penable_i, pwrite_i;
    logic [31:0] paddr_i, pwdata_i;
    logic [3:0]  pstrb_i;
    logic        pready_o, pslverr_o, irq_o;
    logic [31:0] prdata_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    apb_timer dut (
        .clk_i     (clk_i),
        .arst_ni   (arst_ni),
        .psel_i    (psel_i),
        .penable_i (penable_i),
        .paddr_i   (paddr_i),
        .pwrite_i  (pwrite_i),
        .pwdata_i  (pwdata_i),
        .pstrb_i   (pstrb_i),
        .pready_o  (pready_o),
        .prdata_o  (prdata_o),
        .pslverr_o (pslverr_o),
        .irq_o     (irq_o)
    );

    typedef struct packed {
        logic [2:0]  ctrl;
        logic [15:0] pre;
        logic [31:0] cmp;
        logic [31:0] cnt;
        logic        match;
        logic        run;
        logic [31:0] cyc;
    } mdl_t;

    mdl_t m;

    function automatic logic is_err(logic acc, logic wr,
                                    logic [31:0] a, logic [3:0] st);
        return SLVERR && acc && ((a[7:0] >> 2) > 8'd4 || (wr && st == 4'd0));
    endfunction

    function automatic logic [31:0] lanes(logic [31:0] old_v,
                                          logic [31:0] nw,
                                          logic [3:0] st);
        logic [31:0] mask;
        mask = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
        return (old_v & ~mask) | (nw & mask);
    endfunction

    // cyc = cycles spent running since start or last PRESCALE write;
    // a tick closes every (pre+1)-th such cycle.
    function automatic mdl_t step(mdl_t s, logic acc, logic wr,
                                  logic [31:0] a, logic [31:0] wd,
                                  logic [3:0] st);
        mdl_t n;
        logic w, tick, hit;
        logic [31:0] tmp;
        int idx;
        n = s;
        idx = int'(a[7:2]);
        w = acc && wr && !is_err(acc, wr, a, st);
        tick = s.run && ((s.cyc % (32'(s.pre) + 1)) == 32'(s.pre));
        hit = tick && (s.cnt == s.cmp);
        if (tick) n.cnt = hit ? (s.ctrl[1] ? 32'd0 : s.cnt) : s.cnt + 1;
        if (hit) n.match = 1'b1;
        else if (w && idx == 4 && st[0] && wd[0]) n.match = 1'b0;
        if (hit && !s.ctrl[1]) begin
            n.ctrl[0] = 1'b0;
            n.run = 1'b0;
        end
        n.cyc = s.cyc + 1;
        if (w) begin
            case (idx)
                0: if (st[0]) begin
                    n.ctrl = wd[2:0];
                    n.run = wd[0];
                end
                1: begin
                    tmp = lanes({16'd0, s.pre}, wd, st);
                    n.pre = tmp[15:0];
                    n.cyc = 0;
                end
                2: n.cmp = lanes(s.cmp, wd, st);
                3: n.cnt = lanes(s.cnt, wd, st);
                default: ;
            endcase
        end
        if (n.run && !s.run) n.cyc = 0;
        return n;
    endfunction

    function automatic logic [31:0] rd_exp(mdl_t s, logic [31:0] a);
        if (is_err(1'b1, 1'b0, a, 4'hF)) return 32'd0;
        case (int'(a[7:2]))
            0: return {29'd0, s.ctrl};
            1: return {16'd0, s.pre};
            2: return s.cmp;
            3: return s.cnt;
            4: return {31'd0, s.match};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) m <= '0;
        else m <= step(m, psel_i && penable_i, pwrite_i,
                       paddr_i, pwdata_i, pstrb_i);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc_chk(input int n);
        repeat (n) begin
            @(negedge clk_i);
            chk("irq", {31'd0, irq_o}, {31'd0, m.match & m.ctrl[2]});
        end
    endtask

    task automatic apb_wr(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        @(negedge clk_i);
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1;
        paddr_i = a; pwdata_i = d; pstrb_i = s;
        @(negedge clk_i);
        penable_i = 1'b1;
        chk("wr_slverr", {31'd0, pslverr_o},
            {31'd0, is_err(1'b1, 1'b1, a, s)});
        chk("wr_prdata", prdata_o, 32'd0);
        @(negedge clk_i);
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
        chk("irq", {31'd0, irq_o}, {31'd0, m.match & m.ctrl[2]});
    endtask

    task automatic apb_rd(input logic [31:0] a, output logic [31:0] d,
                          output logic e);
        @(negedge clk_i);
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0;
        paddr_i = a; pstrb_i = 4'h0;
        @(negedge clk_i);
        penable_i = 1'b1;
        #1;
        chk($sformatf("rd_%0h", a), prdata_o, rd_exp(m, a));
        chk("rd_slverr", {31'd0, pslverr_o},
            {31'd0, is_err(1'b1, 1'b0, a, 4'h0)});
        d = prdata_o;
        e = pslverr_o;
        @(negedge clk_i);
        psel_i = 1'b0; penable_i = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          n;
        psel_i = 0; penable_i = 0; pwrite_i = 0;
        paddr_i = 0; pwdata_i = 0; pstrb_i = 0;

        repeat (3) @(negedge clk_i);
        chk("rst_irq", {31'd0, irq_o}, 32'd0);
        chk("rst_pready", {31'd0, pready_o}, 32'd1);
        chk("rst_prdata", prdata_o, 32'd0);
        chk("rst_slverr", {31'd0, pslverr_o}, 32'd0);
        arst_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            apb_rd(32'(i * 4), d, e);
            chk("rst_reg", d, 32'd0);
        end

        // auto-reload with irq
        apb_wr(32'h04, 32'd0, 4'hF);
        apb_wr(32'h08, 32'd3, 4'hF);
        apb_wr(32'h00, 32'd7, 4'hF);
        n = 0;
        while (!irq_o && n < 50) begin
            cyc_chk(1);
            n++;
        end
        chk("ar_irq_rise", {31'd0, irq_o}, 32'd1);
        apb_rd(32'h0C, d, e);
        cyc_chk(6);
        apb_wr(32'h00, 32'd6, 4'hF);
        apb_wr(32'h10, 32'd1, 4'h1);
        chk("w1c_irq_drop", {31'd0, irq_o}, 32'd0);

        // one-shot with prescale
        apb_wr(32'h04, 32'd2, 4'hF);
        apb_wr(32'h08, 32'd2, 4'hF);
        apb_wr(32'h0C, 32'd0, 4'hF);
        apb_wr(32'h00, 32'd1, 4'hF);
        cyc_chk(12);
        apb_rd(32'h00, d, e);
        chk("os_ctrl", d, 32'd0);
        apb_rd(32'h0C, d, e);
        chk("os_count", d, 32'd2);
        apb_rd(32'h10, d, e);
        chk("os_match", d, 32'd1);
        chk("os_state", 32'(dut.state_q), 32'(APB_TIMER_DONE));

        // COUNT write on tick cycles
        apb_wr(32'h10, 32'd1, 4'h1);
        apb_wr(32'h04, 32'd0, 4'hF);
        apb_wr(32'h08, 32'hFFFF, 4'hF);
        apb_wr(32'h00, 32'd1, 4'hF);
        cyc_chk(3);
        apb_wr(32'h0C, 32'h10, 4'hF);
        apb_rd(32'h0C, d, e);

        // W1C at several phases against auto-reload matches
        apb_wr(32'h08, 32'd3, 4'hF);
        apb_wr(32'h0C, 32'd0, 4'hF);
        apb_wr(32'h00, 32'd7, 4'hF);
        for (int g = 0; g < 4; g++) begin
            cyc_chk(g);
            apb_wr(32'h10, 32'd1, 4'h1);
            apb_rd(32'h10, d, e);
        end
        apb_wr(32'h00, 32'd0, 4'hF);
        apb_wr(32'h10, 32'd1, 4'h1);

        // wrap without match
        apb_wr(32'h04, 32'd20, 4'hF);
        apb_wr(32'h0C, 32'hFFFF_FFFF, 4'hF);
        apb_wr(32'h08, 32'd5, 4'hF);
        apb_wr(32'h00, 32'd1, 4'hF);
        cyc_chk(22);
        apb_rd(32'h0C, d, e);
        chk("wrap_count", d, 32'd0);
        apb_rd(32'h10, d, e);
        chk("wrap_nomatch", d, 32'd0);
        apb_wr(32'h00, 32'd0, 4'hF);

        // partial strobes
        apb_wr(32'h08, 32'h1234_5678, 4'h3);
        apb_rd(32'h08, d, e);
        chk("strb_cmp", d, 32'h0000_5678);

        // unmapped / empty-strobe access
        apb_rd(32'h20, d, e);
        chk("err_rdata", d, 32'd0);
        chk("err_slverr", {31'd0, e}, {31'd0, SLVERR});
        apb_wr(32'h20, 32'hFFFF_FFFF, 4'hF);
        apb_wr(32'h08, 32'h0000_AAAA, 4'h0);
        apb_rd(32'h08, d, e);
        chk("nostrb_cmp", d, 32'h0000_5678);

        // random traffic
        for (int k = 0; k < 300; k++) begin
            int          op, idx;
            logic [31:0] a, wd;
            op = int'($urandom_range(0, 9));
            idx = int'($urandom_range(0, 6));
            a = 32'(idx * 4) + 32'($urandom_range(0, 3));
            a[31:8] = 24'($urandom);
            case (idx)
                0: wd = 32'($urandom_range(0, 7));
                1: wd = 32'($urandom_range(0, 3));
                2: wd = 32'($urandom_range(0, 6));
                3: wd = 32'($urandom_range(0, 8));
                default: wd = $urandom;
            endcase
            if (op < 5) apb_wr(a, wd, 4'($urandom_range(0, 15)));
            else if (op < 8) apb_rd(a, d, e);
            else cyc_chk(int'($urandom_range(1, 8)));
            if ($urandom_range(0, 59) == 0) begin
                @(negedge clk_i);
                arst_ni = 1'b0;
                @(negedge clk_i);
                chk("mid_rst_irq", {31'd0, irq_o}, 32'd0);
                arst_ni = 1'b1;
                apb_rd(32'h00, d, e);
                chk("mid_rst_ctrl", d, 32'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
